tx_ask_upsampler: RTL and testbench

- Upstream neighbour of the 21-tap transmit pulse-shaping filter.
- Accepts 2-bit Gray-coded 4-ASK symbols over a valid/ready handshake and maps each to a signed 1s17 amplitude.
- Upsamples by zero insertion: one mapped sample followed by UPSAMPLE-1 zeros, one sample per clock.
- Output drives the filter's 18-bit signed sample input directly.

---
 rtl/tx_ask_upsampler.sv | 82 ++++++++
 tb/tb_tx_ask_upsampler.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/tx_ask_upsampler.sv
// Gray-coded 4-ASK symbol mapper with zero-insertion upsampling for the transmit pulse-shaping filter.
// One-entry holding register; a symbol is emitted only at a phase-0 slot and never bypasses the register.
module tx_ask_upsampler #(
    parameter int unsigned UPSAMPLE = 4,
    parameter int unsigned LEVEL    = 32768
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               enable,
    input  logic [1:0]         sym_in,
    input  logic               sym_valid,
    output logic               sym_ready,
    output logic signed [17:0] x_out,
    output logic               sym_strobe,
    output logic               underrun,
    input  logic               clear_underrun
);

    localparam int unsigned PhaseW = $clog2(UPSAMPLE);
    localparam logic [PhaseW-1:0] PhaseLast = PhaseW'(UPSAMPLE - 1);
    localparam logic signed [17:0] AmpInner = 18'(LEVEL);
    localparam logic signed [17:0] AmpOuter = 18'(3 * LEVEL);

    if (UPSAMPLE < 2 || UPSAMPLE > 16 || 3 * LEVEL > 131071) begin : g_param_check
        $error("tx_ask_upsampler: UPSAMPLE must be 2..16 and 3*LEVEL must fit in 1s17");
    end

    logic [PhaseW-1:0]  phase_q;
    logic               hold_valid_q;
    logic [1:0]         hold_sym_q;
    logic signed [17:0] mapped;
    logic               slot;
    logic               take;

    assign sym_ready = !hold_valid_q;
    assign slot      = enable && (phase_q == '0);
    // Transfer only into an empty register, so it can never coincide with consumption.
    assign take      = sym_valid && !hold_valid_q;

    always_comb begin
        mapped = '0;
        case (hold_sym_q)
            2'b00:   mapped = -AmpOuter;
            2'b01:   mapped = -AmpInner;
            2'b11:   mapped = AmpInner;
            default: mapped = AmpOuter;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q      <= '0;
            hold_valid_q <= 1'b0;
            hold_sym_q   <= 2'b00;
            x_out        <= '0;
            sym_strobe   <= 1'b0;
            underrun     <= 1'b0;
        end else begin
            if (take) begin
                hold_valid_q <= 1'b1;
                hold_sym_q   <= sym_in;
            end else if (slot && hold_valid_q) begin
                hold_valid_q <= 1'b0;
            end

            if (enable) begin
                phase_q <= (phase_q == PhaseLast) ? '0 : phase_q + 1'b1;
            end

            sym_strobe <= slot;
            x_out      <= (slot && hold_valid_q) ? mapped : '0;

            // An empty slot outranks a simultaneous clear.
            if (slot && !hold_valid_q) begin
                underrun <= 1'b1;
            end else if (clear_underrun) begin
                underrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_tx_ask_upsampler.sv
// Bench for tx_ask_upsampler: directed literal sequences plus randomized traffic against a
// queue-based behavioural model compared on every falling edge.
module tb_tx_ask_upsampler;

    localparam int U = 4;
    localparam int L = 32768;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               enable = 1'b0;
    logic [1:0]         sym_in = 2'b00;
    logic               sym_valid = 1'b0;
    logic               sym_ready;
    logic signed [17:0] x_out;
    logic               sym_strobe;
    logic               underrun;
    logic               clear_underrun = 1'b0;

    tx_ask_upsampler #(.UPSAMPLE(U), .LEVEL(L)) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .sym_in        (sym_in),
        .sym_valid     (sym_valid),
        .sym_ready     (sym_ready),
        .x_out         (x_out),
        .sym_strobe    (sym_strobe),
        .underrun      (underrun),
        .clear_underrun(clear_underrun)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model state: accepted symbols waiting, sample position, expected registered outputs.
    logic [1:0] pending[$];
    int m_phase = 0;
    int m_x = 0;
    bit m_strobe = 0;
    bit m_under = 0;
    bit cmp_on = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d at time %0t", name, act, exp, $time);
        end
    endtask

    // Gray -> level index 0..3, amplitude (2*idx-3)*L.
    function automatic int amp(input logic [1:0] g);
        int idx;
        idx = {30'd0, g[1], g[1] ^ g[0]};
        return (2 * idx - 3) * L;
    endfunction

    task automatic model_reset();
        pending.delete();
        m_phase = 0;
        m_x = 0;
        m_strobe = 0;
        m_under = 0;
    endtask

    task automatic model_step(input bit en, input bit sv, input logic [1:0] si, input bit clr,
                              input bit rst);
        bit slot;
        bit empty;
        if (rst) begin
            model_reset();
            return;
        end
        slot = en && (m_phase == 0);
        empty = (pending.size() == 0);
        m_strobe = slot;
        m_x = 0;
        if (slot && !empty) m_x = amp(pending.pop_front());
        if (slot && empty) m_under = 1;
        else if (clr) m_under = 0;
        if (sv && empty) pending.push_back(si);
        if (en) m_phase = (m_phase + 1) % U;
    endtask

    task automatic drive_cycle(input bit en, input bit sv, input logic [1:0] si, input bit clr,
                               input bit rst, output bit took);
        enable = en;
        sym_valid = sv;
        sym_in = si;
        clear_underrun = clr;
        reset = rst;
        if (rst) model_reset();
        took = sv && (pending.size() == 0) && !rst;
        @(posedge clk);
        model_step(en, sv, si, clr, rst);
        #1;
    endtask

    always @(negedge clk) begin
        if (cmp_on) begin
            check("x_out", int'(x_out), m_x);
            check("sym_strobe", int'(sym_strobe), int'(m_strobe));
            check("underrun", int'(underrun), int'(m_under));
            check("sym_ready", int'(sym_ready), int'(pending.size() == 0));
        end
    end

    initial begin
        bit took;
        int idx;
        logic [1:0] syms[5];
        int sweep_exp[16];
        bit cur_valid;
        logic [1:0] cur_sym;

        syms = '{2'b00, 2'b01, 2'b11, 2'b10, 2'b10};
        sweep_exp = '{-98304, 0, 0, 0, -32768, 0, 0, 0, 32768, 0, 0, 0, 98304, 0, 0, 0};
        model_reset();
        #2;
        check("reset_x", int'(x_out), 0);
        check("reset_ready", int'(sym_ready), 1);
        drive_cycle(1'b0, 1'b0, 2'b00, 1'b0, 1'b1, took);
        cmp_on = 1;
        reset = 1'b0;

        // Mapping sweep with a source that always has the next symbol ready.
        idx = 0;
        for (int n = 1; n <= 21; n++) begin
            drive_cycle(1'b1, idx < 5, syms[idx < 5 ? idx : 4], 1'b0, 1'b0, took);
            if (took) idx++;
            if (n == 1) check("startup_underrun", int'(underrun), 1);
            if (n >= 5 && n <= 20) check("sweep_x", int'(x_out), sweep_exp[n-5]);
            if (n == 5 || n == 9) check("sweep_strobe", int'(sym_strobe), 1);
            if (n == 6) check("sweep_no_strobe", int'(sym_strobe), 0);
        end
        check("pre_reset_x", int'(x_out), 98304);

        // Asynchronous reset between edges.
        reset = 1'b1;
        model_reset();
        #1;
        check("async_rst_x", int'(x_out), 0);
        check("async_rst_strobe", int'(sym_strobe), 0);
        check("async_rst_under", int'(underrun), 0);
        check("async_rst_ready", int'(sym_ready), 1);
        drive_cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b1, took);
        reset = 1'b0;

        // Clear on an empty slot loses; a symbol taken on an empty slot waits a full period.
        drive_cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, took);
        check("clear_vs_set", int'(underrun), 1);
        for (int n = 2; n <= 4; n++) drive_cycle(1'b1, 1'b0, 2'b00, 1'b1, 1'b0, took);
        check("cleared", int'(underrun), 0);
        drive_cycle(1'b1, 1'b1, 2'b11, 1'b0, 1'b0, took);
        check("collide_x", int'(x_out), 0);
        check("collide_under", int'(underrun), 1);
        check("collide_ready", int'(sym_ready), 0);
        for (int n = 6; n <= 9; n++) drive_cycle(1'b1, 1'b0, 2'b00, 1'b0, 1'b0, took);
        check("collide_late_x", int'(x_out), 32768);

        // Randomized traffic with stalls, clears, backpressure and occasional resets.
        cur_valid = 0;
        cur_sym = 2'b00;
        for (int n = 0; n < 3000; n++) begin
            bit en;
            bit clr;
            bit rst;
            if (!cur_valid && $urandom_range(0, 99) < 60) begin
                cur_valid = 1;
                cur_sym = 2'($urandom_range(0, 3));
            end
            en = ($urandom_range(0, 7) != 0);
            clr = ($urandom_range(0, 15) == 0);
            rst = ($urandom_range(0, 399) == 0);
            drive_cycle(en, cur_valid, cur_sym, clr, rst, took);
            if (took || rst) cur_valid = 0;
        end

        @(negedge clk);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
